// File: rtl/cc_pkg.sv
// Shared constants and state encoding for the cache-line return serializer.
package cc_pkg;

    localparam int CC_LINE_W = 512;
    localparam int CC_BEAT_W = 64;
    localparam int CC_BEATS  = CC_LINE_W / CC_BEAT_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } cc_state_e;

endpackage

// File: rtl/cc_serializer_if.sv
// Line-in / R-channel-out bundle for the cache-line serializer.
// The master modport is the serializer itself; slave is the surrounding logic.
interface cc_serializer_if
    import cc_pkg::*;
#(
    parameter int LINE_W = CC_LINE_W,
    parameter int BEAT_W = CC_BEAT_W
) ();

    logic              line_valid_i;
    logic              line_ready_o;
    logic [LINE_W-1:0] line_data_i;
    logic [5:0]        line_offset_i;
    logic [BEAT_W-1:0] rdata_o;
    logic              rlast_o;
    logic              rvalid_o;
    logic              rready_i;

    modport master (
        input  line_valid_i,
        output line_ready_o,
        input  line_data_i,
        input  line_offset_i,
        output rdata_o,
        output rlast_o,
        output rvalid_o,
        input  rready_i
    );

    modport slave (
        output line_valid_i,
        input  line_ready_o,
        output line_data_i,
        output line_offset_i,
        input  rdata_o,
        input  rlast_o,
        input  rvalid_o,
        output rready_i
    );

endinterface

// File: rtl/cc_serializer.sv
// Cache-line serializer: returns a full line as a critical-word-first wrapped
// burst of beats. A second slot queues the next line so consecutive bursts
// run back to back. Every output comes straight from a flop.
module cc_serializer
    import cc_pkg::*;
#(
    parameter int LINE_W = CC_LINE_W,
    parameter int BEAT_W = CC_BEAT_W
) (
    input  logic               clk,
    input  logic               rst,
    cc_serializer_if.master    bus
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    // Word 0 sits in the most significant beat of the line.
    function automatic logic [BEAT_W-1:0] pick_word(input logic [LINE_W-1:0] line,
                                                    input logic [CNT_W-1:0]  idx);
        pick_word = line[LINE_W - 1 - BEAT_W * int'(idx) -: BEAT_W];
    endfunction

    cc_state_e         state_r,      state_s;
    logic              cur_valid_r,  cur_valid_s;
    logic [LINE_W-1:0] cur_data_r,   cur_data_s;
    logic [CNT_W-1:0]  cur_start_r,  cur_start_s;
    logic [CNT_W-1:0]  cnt_r,        cnt_s;
    logic              pend_valid_r, pend_valid_s;
    logic [LINE_W-1:0] pend_data_r,  pend_data_s;
    logic [CNT_W-1:0]  pend_start_r, pend_start_s;

    logic              rvalid_r,     rvalid_s;
    logic              rlast_r,      rlast_s;
    logic [BEAT_W-1:0] rdata_r,      rdata_s;
    logic              line_ready_r, line_ready_s;

    logic              accept_s;
    logic              beat_hs_s;
    logic              last_hs_s;
    logic [CNT_W-1:0]  new_start_s;
    logic [CNT_W-1:0]  word_idx_s;

    // Next-state and next-output computation for both line slots.
    always_comb begin
        state_s      = state_r;
        cur_valid_s  = cur_valid_r;
        cur_data_s   = cur_data_r;
        cur_start_s  = cur_start_r;
        cnt_s        = cnt_r;
        pend_valid_s = pend_valid_r;
        pend_data_s  = pend_data_r;
        pend_start_s = pend_start_r;

        accept_s    = bus.line_valid_i & line_ready_r;
        beat_hs_s   = rvalid_r & bus.rready_i;
        last_hs_s   = beat_hs_s & (cnt_r == LAST_CNT);
        new_start_s = bus.line_offset_i[5:3];

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s     = ST_SEND;
                    cur_valid_s = 1'b1;
                    cur_data_s  = bus.line_data_i;
                    cur_start_s = new_start_s;
                    cnt_s       = {CNT_W{1'b0}};
                end else begin
                    state_s     = ST_IDLE;
                    cur_valid_s = 1'b0;
                end
            end
            ST_SEND: begin
                if (last_hs_s) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (pend_valid_r) begin
                        // Queued line takes over with no idle cycle in between.
                        cur_data_s   = pend_data_r;
                        cur_start_s  = pend_start_r;
                        pend_valid_s = 1'b0;
                    end else if (accept_s) begin
                        // Line arriving on the final beat bypasses the queue.
                        cur_data_s  = bus.line_data_i;
                        cur_start_s = new_start_s;
                    end else begin
                        state_s     = ST_IDLE;
                        cur_valid_s = 1'b0;
                    end
                end else begin
                    if (beat_hs_s) begin
                        cnt_s = cnt_r + ONE_CNT;
                    end else begin
                        cnt_s = cnt_r;
                    end
                    if (accept_s) begin
                        pend_valid_s = 1'b1;
                        pend_data_s  = bus.line_data_i;
                        pend_start_s = new_start_s;
                    end else begin
                        pend_valid_s = pend_valid_r;
                    end
                end
            end
            default: begin
                state_s      = ST_IDLE;
                cur_valid_s  = 1'b0;
                pend_valid_s = 1'b0;
                cnt_s        = {CNT_W{1'b0}};
            end
        endcase

        // Wrap-around add keeps the burst inside the line.
        word_idx_s   = cur_start_s + cnt_s;
        rvalid_s     = cur_valid_s;
        rlast_s      = cur_valid_s & (cnt_s == LAST_CNT);
        line_ready_s = ~pend_valid_s;
        if (cur_valid_s) begin
            rdata_s = pick_word(cur_data_s, word_idx_s);
        end else begin
            rdata_s = {BEAT_W{1'b0}};
        end
    end

    // State, slot and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cur_valid_r  <= 1'b0;
            cur_data_r   <= {LINE_W{1'b0}};
            cur_start_r  <= {CNT_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            pend_valid_r <= 1'b0;
            pend_data_r  <= {LINE_W{1'b0}};
            pend_start_r <= {CNT_W{1'b0}};
            rvalid_r     <= 1'b0;
            rlast_r      <= 1'b0;
            rdata_r      <= {BEAT_W{1'b0}};
            line_ready_r <= 1'b1;
        end else begin
            state_r      <= state_s;
            cur_valid_r  <= cur_valid_s;
            cur_data_r   <= cur_data_s;
            cur_start_r  <= cur_start_s;
            cnt_r        <= cnt_s;
            pend_valid_r <= pend_valid_s;
            pend_data_r  <= pend_data_s;
            pend_start_r <= pend_start_s;
            rvalid_r     <= rvalid_s;
            rlast_r      <= rlast_s;
            rdata_r      <= rdata_s;
            line_ready_r <= line_ready_s;
        end
    end

    assign bus.rvalid_o     = rvalid_r;
    assign bus.rlast_o      = rlast_r;
    assign bus.rdata_o      = rdata_r;
    assign bus.line_ready_o = line_ready_r;

endmodule

// File: doc/cc_serializer.md
CC_SERIALIZER -- requirements
Module: cc_serializer

Interface
REQ-001 SHALL have parameter LINE_W, 512, cache line width in bits.
REQ-002 SHALL have parameter BEAT_W, 64, R-channel data width in bits; BEATS = LINE_W/BEAT_W = 8.
REQ-003 SHALL have clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have line_valid_i  input  1  a cache line is offered for return.
REQ-006 SHALL have line_ready_o  output  1  serializer accepts the offered line this cycle.
REQ-007 SHALL have line_data_i  input  LINE_W  line payload; word k occupies bits [511-64k : 448-64k].
REQ-008 SHALL have line_offset_i  input  6  request byte offset; bits [5:3] select the critical word.
REQ-009 SHALL have rdata_o  output  BEAT_W  R-channel beat data toward the requester.
REQ-010 SHALL have rlast_o  output  1  final beat of the burst.
REQ-011 SHALL have rvalid_o  output  1  beat valid.
REQ-012 SHALL have rready_i  input  1  requester accepts the beat.

Function
REQ-013 SHALL accept a line on the cycle where line_valid_i and line_ready_o are both high.
REQ-014 SHALL hold two line slots: current (being serialized) and pending (queued), each with data, start word and valid bit.
REQ-015 SHALL drive line_ready_o = !pending_valid, from registers only, with no combinational path from line_valid_i or rready_i.
REQ-016 SHALL implement states IDLE (current empty) and SEND (current valid).
REQ-017 IDLE: an accepted line loads into current, beat count = 0, next state SEND; rvalid_o high on the following cycle, giving 1-cycle latency.
REQ-018 SEND: rvalid_o = 1; rdata_o = current word ((start + cnt) mod 8), 3-bit wrap-around add.
REQ-019 SHALL assert rlast_o exactly when rvalid_o = 1 and cnt = 7.
REQ-020 SHALL advance cnt only on a beat handshake (rvalid_o and rready_i); rdata_o and rlast_o stay stable while rvalid_o = 1 and rready_i = 0.
REQ-021 SEND with no last-beat handshake: an accepted line loads into pending.
REQ-022 On the last-beat handshake: if pending is valid, it moves to current, cnt = 0, state stays SEND, so the next burst follows with no idle cycle; pending is cleared.
REQ-023 On the last-beat handshake with pending empty and a simultaneous accept: the new line loads directly into current, cnt = 0, state stays SEND.
REQ-024 On the last-beat handshake with pending empty and no accept: next state IDLE, rvalid_o low the next cycle.
REQ-025 With pending full and a line offered, line_ready_o = 0 and the line is not captured; it SHALL be accepted in the cycle after pending drains.
REQ-026 SHALL emit exactly 8 beats per accepted line, in wrapped order starting at line_offset_i[5:3], and return lines in acceptance order.

Reset
REQ-027 While rst = 1 at a clock edge: state = IDLE, current_valid = 0, pending_valid = 0, cnt = 0.
REQ-028 Output values after reset: rvalid_o = 0, rlast_o = 0, rdata_o = 0, line_ready_o = 1.
REQ-029 Reset mid-burst SHALL discard the current and pending lines without completing them; no further beats are produced.

Structure
REQ-030 Shared package cc_pkg SHALL hold CC_LINE_W, CC_BEAT_W, CC_BEATS and the serializer state enum.
REQ-031 SHALL be a single module with no sub-module; both line slots are in-module registers.

Verification
REQ-032 Offset 0x00, line words W0..W7 = 0x0..0x7 replicated, rready_i = 1 -> beats 0..7 on consecutive cycles starting 1 cycle after accept; rlast_o on beat 7 only.
REQ-033 Offset 0x28 (word 5) -> beat order 5,6,7,0,1,2,3,4; rlast_o with word 4.
REQ-034 rready_i = 0 for 3 cycles at beat 2 -> rdata_o and rlast_o stable during the stall; count resumes at beat 2; still exactly 8 beats.
REQ-035 Three lines offered back to back, rready_i = 1 -> line_ready_o drops after the 2nd accept; 24 beats with no gap between bursts; the 3rd line is accepted after line 1's last beat.
REQ-036 Line offered in the same cycle as the last-beat handshake with pending empty -> next cycle shows the new line's first beat, with no IDLE bubble.
REQ-037 rst = 1 at beat 4 with pending valid -> next cycle rvalid_o = 0, line_ready_o = 1; no stale beats after rst is released.
